// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage. Shift-add multiply and
// restoring divide retire one bit per cycle; the HI/LO pair is written in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             annul_i,
  output logic             stallreq_o,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o,
  output logic [1:0]       state_o
);

  // Handshake: start_i is a level request held by EX; the unit stalls the
  // pipeline until the one-cycle ready_o pulse, during which stall is released.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, RESULT = 2'd3} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     a_raw_q, opa_q, opb_q;
  logic                 neg_q, rem_neg_q, bzero_q, ovf_q;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH:0]       rem;

  logic                 in_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic                 div_borrow;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rmd;

  always_comb begin
    in_signed = ~op_i[0];
    a_neg     = in_signed & src_a_i[WIDTH-1];
    b_neg     = in_signed & src_b_i[WIDTH-1];
    a_abs     = a_neg ? -src_a_i : src_a_i;
    b_abs     = b_neg ? -src_b_i : src_b_i;
  end

  // Multiply keeps the multiplier in acc[W-1:0]; divide keeps the dividend
  // there and shifts quotient bits in behind it.
  always_comb begin
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa_q} : '0);
    div_shift  = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_borrow = div_shift < {1'b0, opb_q};
    div_diff   = div_shift - {1'b0, opb_q};
    prod       = neg_q ? -acc : acc;
    quo        = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd        = rem_neg_q ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_comb begin
    stallreq_o = !rst && !annul_i &&
                 ((state == IDLE && start_i) || state == CALC || state == FIX);
  end

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      op_q          <= '0;
      a_raw_q       <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      neg_q         <= 1'b0;
      rem_neg_q     <= 1'b0;
      bzero_q       <= 1'b0;
      ovf_q         <= 1'b0;
      acc           <= '0;
      rem           <= '0;
      busy_o        <= 1'b0;
      ready_o       <= 1'b0;
      hi_o          <= '0;
      lo_o          <= '0;
      div_by_zero_o <= 1'b0;
    end else if (annul_i && (state == CALC || state == FIX)) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      ready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b0;
          if (start_i && !annul_i) begin
            op_q      <= op_i;
            a_raw_q   <= src_a_i;
            opa_q     <= a_abs;
            opb_q     <= b_abs;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            bzero_q   <= (src_b_i == '0);
            ovf_q     <= (src_a_i == MOST_NEG) && (src_b_i == '1);
            acc       <= {{WIDTH{1'b0}}, (op_i[1] ? a_abs : b_abs)};
            rem       <= '0;
            cnt       <= '0;
            busy_o    <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (op_q[1]) begin
            rem              <= div_borrow ? div_shift : div_diff;
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ~div_borrow};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (!op_q[1]) begin
            hi_o          <= prod[2*WIDTH-1:WIDTH];
            lo_o          <= prod[WIDTH-1:0];
            div_by_zero_o <= 1'b0;
          end else if (bzero_q) begin
            hi_o          <= a_raw_q;
            lo_o          <= '1;
            div_by_zero_o <= 1'b1;
          end else if (!op_q[0] && ovf_q) begin
            hi_o          <= '0;
            lo_o          <= MOST_NEG;
            div_by_zero_o <= 1'b0;
          end else begin
            hi_o          <= rmd;
            lo_o          <= quo;
            div_by_zero_o <= 1'b0;
          end
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          state   <= RESULT;
        end
        RESULT: begin
          ready_o <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit and an 8-bit instance driven by directed and
// random operations, results scored against an arithmetic reference model.
module tb_muldiv_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start32, annul32, stall32, busy32, ready32, dz32;
  logic [1:0]  op32, st32;
  logic [31:0] a32, b32, hi32, lo32;

  logic        start8, annul8, stall8, busy8, ready8, dz8;
  logic [1:0]  op8, st8;
  logic [7:0]  a8, b8, hi8, lo8;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .op_i(op32), .src_a_i(a32), .src_b_i(b32),
    .annul_i(annul32), .stallreq_o(stall32), .busy_o(busy32), .ready_o(ready32),
    .hi_o(hi32), .lo_o(lo32), .div_by_zero_o(dz32), .state_o(st32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op8), .src_a_i(a8), .src_b_i(b8),
    .annul_i(annul8), .stallreq_o(stall8), .busy_o(busy8), .ready_o(ready8),
    .hi_o(hi8), .lo_o(lo8), .div_by_zero_o(dz8), .state_o(st8)
  );

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  logic [64:0] last_exp;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result packed as {div_by_zero, hi (32), lo (32)}.
  function automatic logic [64:0] ref_model(input int w, input logic [1:0] op,
                                            input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, a, b, p, hi, lo;
    longint sa, sb, mn;
    logic dz;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    sa = longint'(a << (64 - w)) >>> (64 - w);
    sb = longint'(b << (64 - w)) >>> (64 - w);
    mn = -(longint'(1) <<< (w - 1));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); hi = (p >> w) & mask; lo = p & mask; end
      2'b01: begin p = a * b;        hi = (p >> w) & mask; lo = p & mask; end
      2'b10: begin
        if (b == 0) begin lo = mask; hi = a; dz = 1'b1; end
        else if (sa == mn && sb == -1) begin lo = 64'(mn) & mask; hi = '0; end
        else begin lo = 64'(sa / sb) & mask; hi = 64'(sa % sb) & mask; end
      end
      default: begin
        if (b == 0) begin lo = mask; hi = a; dz = 1'b1; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
    return {dz, hi[31:0], lo[31:0]};
  endfunction

  function automatic logic [64:0] obs_res(input int w);
    if (w == 32) return {dz32, hi32, lo32};
    return {dz8, 24'h0, hi8, 24'h0, lo8};
  endfunction

  function automatic logic obs_ready(input int w);
    return (w == 32) ? ready32 : ready8;
  endfunction

  function automatic logic obs_stall(input int w);
    return (w == 32) ? stall32 : stall8;
  endfunction

  // ---------------- driver ----------------
  // Called just after a negedge in IDLE; returns at the negedge after the ready cycle.
  task automatic run_op(input int w, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [64:0] exp);
    int c, stall_cnt;
    bit got;
    exp_q.push_back(exp);
    if (w == 32) begin start32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0]; end
    else         begin start8  = 1'b1; op8  = op; a8  = a[7:0];  b8  = b[7:0];  end
    c = 0; stall_cnt = 0; got = 1'b0;
    while (!got && c < 200) begin
      #1;
      if (obs_stall(w)) stall_cnt++;
      if (obs_ready(w)) got = 1'b1;
      else begin
        @(negedge clk);
        if (c == 0) begin
          // operands change after the start edge must not matter
          if (w == 32) begin op32 = 2'($urandom_range(0, 3)); a32 = $urandom; b32 = $urandom; end
          else begin op8 = 2'($urandom_range(0, 3)); a8 = 8'($urandom); b8 = 8'($urandom); end
        end
        c++;
      end
    end
    check($sformatf("latency_w%0d", w), 65'(c), 65'(w + 2));
    check($sformatf("stall_cycles_w%0d", w), 65'(stall_cnt), 65'(w + 2));
    check($sformatf("result_w%0d_op%0d", w, op), obs_res(w), exp_q.pop_front());
    if (w == 32) start32 = 1'b0; else start8 = 1'b0;
    last_exp = exp;
    @(negedge clk);
  endtask

  function automatic logic [63:0] pick_b(input int w);
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return (w == 32) ? 64'hFFFF_FFFF : 64'hFF;
      2:       return 64'($urandom_range(1, 15));
      default: return {32'h0, $urandom};
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0]  rop;
    logic [63:0] ra, rb;
    int stall_cnt;
    bit saw_ready;

    rst = 1'b1; start32 = 1'b1; annul32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
    start8 = 1'b1; annul8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check("reset_stall32", 65'(stall32), 65'd0);
    check("reset_res32", {dz32, hi32, lo32}, 65'd0);
    check("reset_ctrl32", {63'd0, ready32, busy32}, 65'd0);
    check("reset_res8", obs_res(8), 65'd0);
    start32 = 1'b0; start8 = 1'b0; rst = 1'b0;
    last_exp = '0;
    @(negedge clk);

    run_op(32, 2'b00, 64'hFFFF_FFFD, 64'd5,          {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
    run_op(32, 2'b01, 64'hFFFF_FFFF, 64'hFFFF_FFFF,  {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    run_op(32, 2'b10, 64'hFFFF_FFF9, 64'd2,          {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(32, 2'b11, 64'd100,       64'd7,          {1'b0, 32'h0000_0002, 32'h0000_000E});
    run_op(32, 2'b10, 64'h8000_0000, 64'hFFFF_FFFF,  {1'b0, 32'h0000_0000, 32'h8000_0000});
    run_op(32, 2'b11, 64'h1234_5678, 64'd0,          {1'b1, 32'h1234_5678, 32'hFFFF_FFFF});
    run_op(32, 2'b00, 64'd7,         64'hFFFF_FFFE,  {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF2});

    // annul on the 10th CALC cycle of div 100/7
    start32 = 1'b1; op32 = 2'b10; a32 = 32'd100; b32 = 32'd7;
    stall_cnt = 0; saw_ready = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) annul32 = 1'b1;
      #1;
      if (ready32) saw_ready = 1'b1;
      if (c < 10 && stall32) stall_cnt++;
      if (c == 10) check("annul_stall", 65'(stall32), 65'd0);
      @(negedge clk);
    end
    annul32 = 1'b0;
    check("pre_annul_stall", 65'(stall_cnt), 65'd10);
    check("annul_no_ready", 65'(saw_ready), 65'd0);
    check("annul_busy", 65'(busy32), 65'd0);
    check("annul_hold", {dz32, hi32, lo32}, last_exp);
    run_op(32, 2'b01, 64'd3, 64'd4, {1'b0, 32'h0, 32'h0000_000C});

    // annul while IDLE blocks the start
    start32 = 1'b1; annul32 = 1'b1; op32 = 2'b01; a32 = 32'd9; b32 = 32'd9;
    #1 check("idle_annul_stall", 65'(stall32), 65'd0);
    @(negedge clk);
    check("idle_annul_busy", 65'(busy32), 65'd0);
    start32 = 1'b0; annul32 = 1'b0;
    @(negedge clk);

    // random operations, scored against the reference model
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 4) == 0) ? 64'h8000_0000 : {32'h0, $urandom};
      rb = pick_b(32);
      run_op(32, rop, ra, rb, ref_model(32, rop, ra, rb));
    end

    // reset in the middle of CALC
    start32 = 1'b1; op32 = 2'b01; a32 = $urandom; b32 = $urandom;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_res", {dz32, hi32, lo32}, 65'd0);
    check("midrst_ctrl", {62'd0, ready32, busy32, stall32}, 65'd0);
    rst = 1'b0; start32 = 1'b0; saw_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1 if (ready32) saw_ready = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_ready", 65'(saw_ready), 65'd0);

    // 8-bit instance
    run_op(8, 2'b00, 64'h80, 64'h80, {1'b0, 32'h40, 32'h00});
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 64'h80 : 64'($urandom_range(0, 255));
      rb = pick_b(8) & 64'hFF;
      run_op(8, rop, ra, rb, ref_model(8, rop, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the EX stage, with operand width set by a parameter. It executes signed and unsigned multiply and divide one bit per cycle and writes a HI/LO result pair. While an operation is in flight it requests a pipeline stall. It accepts an annul to cancel in-flight work and flags division by zero.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 4. HI and LO are each WIDTH bits.
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start_i  input  1  operation request; held high by EX while the instruction is resident
- op_i  input  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu
- src_a_i  input  WIDTH  multiplicand or dividend
- src_b_i  input  WIDTH  multiplier or divisor
- annul_i  input  1  cancel; has priority over everything except rst
- stallreq_o  output  1  combinational stall request to the stall controller
- busy_o  output  1  registered; high in CALC and FIX
- ready_o  output  1  registered one-cycle pulse; result valid
- hi_o  output  WIDTH  mult: product[2W-1:W]; div: remainder
- lo_o  output  WIDTH  mult: product[W-1:0]; div: quotient
- div_by_zero_o  output  1  valid with ready_o; high for div/divu with src_b_i = 0

## Operation
- States:
  - IDLE: accepts a new operation.
  - CALC: iterates; a counter runs 0 to WIDTH-1.
  - FIX: applies sign correction and registers the outputs.
  - RESULT: ready_o = 1.
- IDLE, start_i=1 and annul_i=0:
  - Latch op_i, src_a_i and src_b_i.
  - Latch |src_a_i| and |src_b_i| for signed ops; raw values otherwise.
  - Record the result signs.
  - Clear the counter and go to CALC.
- CALC, multiply: shift-add, one multiplier bit per cycle into a 2W-bit accumulator.
- CALC, divide: restoring, one quotient bit per cycle. The partial remainder is W+1 bits.
- CALC exits to FIX after the iteration with counter = WIDTH-1.
- FIX signs:
  - Signed mult: negate the 2W-bit product if src_a and src_b signs differ.
  - Signed div: quotient negated if the signs differ; remainder takes the dividend's sign.
- FIX special cases:
  - Division by zero (either div op): lo_o = all ones, hi_o = raw src_a, div_by_zero_o = 1. Latency is unchanged.
  - Signed div of the most-negative value by -1: lo_o = most-negative value, hi_o = 0. No flag.
- FIX then registers hi_o, lo_o and div_by_zero_o, sets ready_o and goes to RESULT.
- RESULT: ready_o high for this cycle only; start_i is ignored; next state is IDLE.
- hi_o, lo_o and div_by_zero_o hold their values until the next FIX. div_by_zero_o is cleared in FIX for non-zero divides and for multiplies.
- stallreq_o = !rst & !annul_i & ((IDLE & start_i) | CALC | FIX). It is low in RESULT, so the pipeline advances on the ready cycle.
- annul_i in CALC or FIX: next state is IDLE. No ready pulse is produced; hi_o, lo_o and div_by_zero_o are unchanged.
- annul_i in IDLE: start_i is ignored.
- annul_i in RESULT: has no effect; the pulse already occurred.
- op_i and src changes after the start edge are ignored; the latched values are used.

## Timing
- Reset (synchronous): state = IDLE, counter = 0.
  - hi_o, lo_o, ready_o, busy_o and div_by_zero_o are 0.
  - stallreq_o is 0 while rst is high.
- Start sampled at edge k:
  - CALC occupies cycles k+1 … k+WIDTH.
  - FIX is cycle k+WIDTH+1.
  - ready_o is high in cycle k+WIDTH+2 (edge k+WIDTH+1 drives it).
- stallreq_o is high in cycles k … k+WIDTH+1, which is WIDTH+2 cycles (34 for WIDTH=32). It is low in the ready cycle.
- Back-to-back: the earliest next start is sampled in the cycle after RESULT (IDLE). The restart interval is WIDTH+3 cycles.
- rst mid-operation behaves as reset: IDLE, outputs cleared, no ready pulse.
- Annul at edge j during CALC or FIX: the state is IDLE from cycle j+1. A start at edge j+1 is accepted normally.

## Test plan
- WIDTH=32, mult: src_a = FFFFFFFD (-3), src_b = 00000005 → hi = FFFFFFFF, lo = FFFFFFF1. ready_o is high exactly 34 cycles after the start cycle, and stallreq_o is high for 34 cycles.
- multu: FFFFFFFF × FFFFFFFF → hi = FFFFFFFE, lo = 00000001.
- Divide results:
  - div: FFFFFFF9 (-7) / 2 → lo = FFFFFFFD, hi = FFFFFFFF.
  - divu: 100 / 7 → lo = 0000000E, hi = 00000002.
  - div: 80000000 / FFFFFFFF → lo = 80000000, hi = 0, flag 0.
- Division by zero: divu 12345678 / 0 → lo = FFFFFFFF, hi = 12345678, div_by_zero_o = 1 during ready. A following mult clears the flag.
- Annul:
  - Start div 100/7, then pulse annul_i on the 10th CALC cycle → no ready pulse; stallreq_o drops in the annul cycle; hi/lo keep the prior values.
  - A new multu 3×4 issued the next cycle → lo = 0000000C, hi = 0.
- Reset and parametrisation:
  - Assert rst during CALC → all outputs 0 next cycle; no ready pulse.
  - Re-run at WIDTH=8: mult 0x80 × 0x80 → {hi, lo} = 0x4000; ready_o 10 cycles after start.
